// File: rtl/tt_spine_ctrl.sv
// tt_spine_ctrl: spine-root driver; holds the design-select address and blanks the enable around every change.
// Define TT_SPINE_CTRL_SEL_LOAD_EN to add a valid/ready direct address load.
module tt_spine_ctrl #(
    parameter int N_IO      = 8,
    parameter int N_O       = 8,
    parameter int N_I       = 10,
    parameter int BLANK_CYC = 3,
    parameter int S_OW      = N_O + 2*N_IO + 2,
    parameter int S_IW      = N_I + N_IO + 12,
    parameter int U_OW      = N_O + 2*N_IO,
    parameter int U_IW      = N_I + N_IO
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ctrl_sel_rst_n,
    input  logic            ctrl_sel_inc,
    input  logic            ctrl_ena,
`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
    input  logic            sel_load_valid,
    input  logic [8:0]      sel_load_data,
    output logic            sel_load_ready,
`endif
    input  logic [U_IW-1:0] pad_usr_in,
    output logic [U_OW-1:0] pad_usr_out,
    output logic [S_IW-1:0] spine_iw,
    input  logic [S_OW-1:0] spine_ow,
    output logic [8:0]      cur_sel,
    output logic            cur_ena
);
    localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    typedef enum logic {IDLE, BLANK} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    sel_q, sel_d, load_data;
    logic [2:0]    s1_q, s2_q;
    logic          inc_q, ena_q, ena_d, ready_q, ready_d;
    logic          srst_n, sinc, sena, inc_pulse, change, load_fire;
    logic          unused_guards;

    // Pad controls are slow and asynchronous: {sel_rst_n, inc, ena}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 3'b100;
            s2_q  <= 3'b100;
            inc_q <= 1'b0;
        end else begin
            s1_q  <= {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena};
            s2_q  <= s1_q;
            inc_q <= s2_q[1];
        end
    end

    assign {srst_n, sinc, sena} = s2_q;
    assign inc_pulse = sinc & ~inc_q;

`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
    assign sel_load_ready = ready_q & srst_n;
    assign load_fire      = sel_load_valid & sel_load_ready;
    assign load_data      = sel_load_data;
`else
    assign load_fire      = 1'b0;
    assign load_data      = 9'd0;
`endif

    // Priority rst > load > inc; a change is any actual difference in value.
    always_comb begin
        sel_d = !srst_n ? 9'd0 : load_fire ? load_data : inc_pulse ? sel_q + 9'd1 : sel_q;
    end

    assign change = sel_d != sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= CW'(BLANK_CYC - 1);
            sel_q   <= 9'd0;
            ena_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (change) begin
            state_d = BLANK;
            cnt_d   = CW'(BLANK_CYC - 1);
        end else if (state_q == BLANK) begin
            state_d = (cnt_q == '0) ? IDLE : BLANK;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        end
    end

    // Enable falls on the same edge the address moves, so the two never skew.
    always_comb begin
        ready_d = (state_q == IDLE) & ~change;
        ena_d   = sena & ready_d;
    end

    assign spine_iw      = {1'b0, {U_IW{ena_q}} & pad_usr_in, sel_q, ena_q, 1'b0};
    assign pad_usr_out   = spine_ow[S_OW-2:1];
    assign unused_guards = &{1'b0, spine_ow[S_OW-1], spine_ow[0], ready_q};
    assign cur_sel       = sel_q;
    assign cur_ena       = ena_q;
endmodule

// File: tb/tb_tt_spine_ctrl.sv
// tb_tt_spine_ctrl: vector table, directed corner sequences and random pads against an address/age reference model.
module tb_tt_spine_ctrl;
    localparam int BC = 3;

    typedef struct {
        logic [25:0] ow;
        logic [17:0] ui;
        logic [23:0] eo;
        logic [17:0] eu;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        ctrl_sel_rst_n = 1'b1, ctrl_sel_inc = 1'b0, ctrl_ena = 1'b0;
    logic [17:0] pad_usr_in = '0;
    logic [23:0] pad_usr_out;
    logic [29:0] spine_iw;
    logic [25:0] spine_ow = '0;
    logic [8:0]  cur_sel;
    logic        cur_ena;
`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
    logic        sel_load_valid = 1'b0;
    logic [8:0]  sel_load_data = '0;
    logic        sel_load_ready;
`endif

    int checks = 0, failures = 0;
    int m_sel, m_age;
    bit m_ena, m_rdyq;
    bit [2:0] hr, hi, he;   // pad values presented 1, 2, 3 edges ago
    vec_t tbl[4];

    always #5 clk = ~clk;

    tt_spine_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
        .sel_load_valid(sel_load_valid), .sel_load_data(sel_load_data), .sel_load_ready(sel_load_ready),
`endif
        .pad_usr_in(pad_usr_in), .pad_usr_out(pad_usr_out),
        .spine_iw(spine_iw), .spine_ow(spine_ow),
        .cur_sel(cur_sel), .cur_ena(cur_ena)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pad level reaches the control logic two edges late; an address change restarts
    // the age count, and enable/ready need the age to exceed the blanking length.
    task automatic step();
        bit cr, ci, ce, ld;
        int old, ldat;
        logic [29:0] exp_iw;
        cr = ctrl_sel_rst_n; ci = ctrl_sel_inc; ce = ctrl_ena; ld = 0; ldat = 0;
`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
        ld = sel_load_valid && m_rdyq && hr[1];
        ldat = int'(sel_load_data);
`endif
        @(posedge clk);
        old = m_sel;
        if (!hr[1]) m_sel = 0;
        else if (ld) m_sel = ldat;
        else if (hi[1] && !hi[2]) m_sel = (m_sel + 1) % 512;
        m_age = (m_sel != old) ? 0 : (m_age < 100 ? m_age + 1 : m_age);
        m_ena = he[1] && (m_age > BC);
        m_rdyq = m_age > BC;
        hr = {hr[1:0], cr};
        hi = {hi[1:0], ci};
        he = {he[1:0], ce};
        #1;
        exp_iw = {1'b0, m_ena ? pad_usr_in : 18'h0, 9'(m_sel), m_ena, 1'b0};
        chk("spine_iw", 64'(spine_iw), 64'(exp_iw));
        chk("cur_sel", 64'(cur_sel), 64'(m_sel));
        chk("cur_ena", 64'(cur_ena), 64'(m_ena));
        chk("pad_usr_out", 64'(pad_usr_out), (64'(spine_ow) >> 1) & 64'hFF_FFFF);
`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
        chk("sel_load_ready", 64'(sel_load_ready), 64'(m_rdyq && hr[1]));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_iw", 64'(spine_iw), 64'h0);
        chk("rst_sel", 64'(cur_sel), 64'h0);
        chk("rst_ena", 64'(cur_ena), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_sel = 0; m_age = 0; m_ena = 0; m_rdyq = 0;
        hr = 3'b111; hi = 3'b000; he = 3'b000;
    endtask

    task automatic pulse(input int h, input int l);
        ctrl_sel_inc = 1'b1;
        repeat (h) step();
        ctrl_sel_inc = 1'b0;
        repeat (l) step();
    endtask

`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
    task automatic load(input logic [8:0] d);
        bit ok, rdy;
        ok = 0;
        sel_load_valid = 1'b1;
        sel_load_data = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            rdy = m_rdyq && hr[1];
            step();
            ok = rdy;
        end
        sel_load_valid = 1'b0;
        chk("load_handshake", 64'(ok), 64'h1);
    endtask
`endif

    initial begin
        tbl[0] = '{26'h2B4B4B5, 18'h002A5, 24'h5A5A5A, 18'h002A5};
        tbl[1] = '{26'h1FFFFFE, 18'h3FFFF, 24'hFFFFFF, 18'h3FFFF};
        tbl[2] = '{26'h2000001, 18'h00000, 24'h000000, 18'h00000};
        tbl[3] = '{26'h02468AC, 18'h2AAAA, 24'h123456, 18'h2AAAA};

        ctrl_ena = 1'b1;
        pad_usr_in = 18'h2A5;
        #2;
        do_reset();
        repeat (3) step();
        chk("blank_after_reset", 64'(cur_ena), 64'h0);
        step();
        chk("ena_after_reset", 64'(cur_ena), 64'h1);
        chk("usr_pass", 64'(spine_iw[28:11]), 64'h2A5);

        repeat (5) pulse(10, 10);
        chk("sel_5", 64'(cur_sel), 64'd5);
        repeat (506) pulse(2, 2);
        chk("sel_511", 64'(cur_sel), 64'd511);
        pulse(2, 2);
        chk("wrap_sel", 64'(cur_sel), 64'd0);
        chk("wrap_blank", 64'(cur_ena), 64'h0);

        repeat (7) pulse(2, 2);
        repeat (6) step();
        chk("sel_7", 64'(cur_sel), 64'd7);
        ctrl_sel_rst_n = 1'b0;
        ctrl_sel_inc = 1'b1;
        repeat (6) step();
        chk("rst_beats_inc", 64'(cur_sel), 64'd0);
        repeat (3) begin
            ctrl_sel_inc = 1'b0; step(); step();
            ctrl_sel_inc = 1'b1; step(); step();
        end
        ctrl_sel_inc = 1'b0;
        step(); step();
        chk("rst_hold", 64'(cur_sel), 64'd0);
        ctrl_sel_rst_n = 1'b1;
        repeat (6) step();
        chk("no_spurious", 64'(cur_sel), 64'd0);
        pulse(2, 2);
        chk("after_rst", 64'(cur_sel), 64'd1);

        repeat (8) step();
        foreach (tbl[i]) begin
            spine_ow = tbl[i].ow;
            pad_usr_in = tbl[i].ui;
            #1;
            chk("tbl_pad_out", 64'(pad_usr_out), 64'(tbl[i].eo));
            chk("tbl_usr", 64'(spine_iw[28:11]), 64'(tbl[i].eu));
            step();
        end

        spine_ow = 26'h2B4B4B5;
        ctrl_sel_inc = 1'b1;
        repeat (3) step();
        chk("mid_blank", 64'(cur_ena), 64'h0);
        ctrl_sel_inc = 1'b0;
        do_reset();
        chk("pad_out_in_reset", 64'(pad_usr_out), 64'h5A5A5A);

        repeat (3000) begin
            if ($urandom_range(2) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
            if ($urandom_range(39) == 0) ctrl_sel_rst_n = ~ctrl_sel_rst_n;
            if ($urandom_range(19) == 0) ctrl_ena = ~ctrl_ena;
            pad_usr_in = 18'($urandom);
            spine_ow = 26'($urandom);
            step();
        end
        ctrl_sel_rst_n = 1'b1;
        ctrl_sel_inc = 1'b0;
        ctrl_ena = 1'b1;
        repeat (10) step();

`ifdef TT_SPINE_CTRL_SEL_LOAD_EN
        load(9'h1C3);
        chk("load_sel", 64'(cur_sel), 64'h1C3);
        chk("load_rdy0", 64'(sel_load_ready), 64'h0);
        repeat (3) begin
            step();
            chk("load_rdy_low", 64'(sel_load_ready), 64'h0);
        end
        step();
        chk("load_rdy_back", 64'(sel_load_ready), 64'h1);
        load(9'h1C3);
        chk("eq_load_ena", 64'(cur_ena), 64'h1);
        step();
        chk("eq_load_ena2", 64'(cur_ena), 64'h1);
        ctrl_sel_inc = 1'b1;
        step(); step();
        sel_load_valid = 1'b1;
        sel_load_data = 9'h0AB;
        step();
        sel_load_valid = 1'b0;
        chk("load_beats_inc", 64'(cur_sel), 64'h0AB);
        ctrl_sel_inc = 1'b0;
        repeat (6) step();
        chk("load_inc_final", 64'(cur_sel), 64'h0AB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_spine_ctrl.md
Name: tt_spine_ctrl

Overview:
- Head-end driver of the vertical spine; the counterpart of the per-row mux that decodes the spine.
- Holds the 9-bit design-select address (4-bit branch + 5-bit block), stepped by slow pad-level control inputs.
- Generates a glitch-free design enable around every address change.
- Drives user inputs onto the spine and returns spine outputs to pads. One instance per chip, at the spine root.

Parameters:
- N_IO, 8, bidirectional user IO count
- N_O, 8, user output count
- N_I, 10, user input count
- BLANK_CYC, 3, cycles the enable stays low after any address change (min 1)
- S_OW, N_O+2*N_IO+2, derived spine outward width
- S_IW, N_I+N_IO+12, derived spine inward width
- U_OW, N_O+2*N_IO, derived user outward width
- U_IW, N_I+N_IO, derived user inward width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ctrl_sel_rst_n  in  1  async pad input; low forces address to 0
- ctrl_sel_inc  in  1  async pad input; each rising edge increments address
- ctrl_ena  in  1  async pad input; requested design enable
- pad_usr_in  in  U_IW  user inputs from pads
- pad_usr_out  out  U_OW  user outputs/oe to pads
- spine_iw  out  S_IW  spine inward bus {gh, usr[U_IW], sel[8:0], ena, gl}
- spine_ow  in  S_OW  spine outward bus {gh, usr[U_OW], gl}
- cur_sel  out  9  current address (debug/readback)
- cur_ena  out  1  current spine enable

Behaviour:
- Synchronisers: ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena each pass through a 2-FF synchroniser. Reset values: 1, 0, 0. inc_pulse = sync_inc & ~inc_d (registered rising-edge detect).
- Address counter sel[8:0], reset 0:
  - sync_sel_rst_n==0: sel <= 0; counts as a change only if sel was nonzero.
  - else if inc_pulse: sel <= sel+1, modulo 512 (511 wraps to 0).
  - rst has priority over a simultaneous inc; that inc is dropped.
  - Edges arriving while rst is held low are ignored. An edge detector primed before rst deasserts fires nothing spurious.
- Blank FSM, states IDLE / BLANK, reset to BLANK with cnt=BLANK_CYC-1 so ena is low for BLANK_CYC cycles after reset:
  - Any sel change: go to BLANK, cnt <= BLANK_CYC-1. A change during BLANK reloads cnt.
  - BLANK: cnt decrements each cycle; at cnt==0, go to IDLE next cycle.
  - IDLE: no blanking.
- ena register, reset 0: ena <= sync_ena & (state==IDLE) & ~change_this_cycle. ena drops in the same cycle sel updates; both are registered together, so sel and ena never glitch relative to each other.
- Latency:
  - pad inc edge to sel update: 3 clk.
  - sel update to ena re-high: BLANK_CYC+1 clk, if ctrl_ena is held high.
- spine_iw:
  - guards gh/gl driven constant 0.
  - sel field = sel register.
  - ena field = ena register.
  - usr field = pad_usr_in when ena==1, else all-zero (combinational gate).
- pad_usr_out = spine_ow[S_OW-2:1], combinational. Guard bits are ignored.
- cur_sel = sel; cur_ena = ena.
- Reset mid-operation: all registers return to their reset values asynchronously. spine_iw immediately shows sel=0, ena=0, usr=0.

Optional Feature:
- Macro TT_SPINE_CTRL_SEL_LOAD_EN.
- Defined: adds ports sel_load_valid (in 1), sel_load_data (in 9), sel_load_ready (out 1, reset 0).
- sel_load_ready is high only in IDLE with sync_sel_rst_n==1.
- A transfer (valid & ready) loads sel <= sel_load_data in the next cycle.
- Priority: rst > load > inc. An inc edge coinciding with a load is dropped.
- A load to a different value counts as a change and enters BLANK. A load of an identical value is consumed without blanking.
- Undefined: the ports are absent and behaviour is exactly as above.

Test Plan:
- Reset release with ctrl_ena=1: sel=0; ena low for BLANK_CYC(3) cycles after the synchroniser delay, then ena=1; spine_iw usr field equals pad_usr_in (0x2A5 → 0x2A5).
- 5 inc pulses (10 clk high/low each): cur_sel=5; ena drops within the same cycle of each step and returns 4 clk later; usr field reads 0 while ena=0.
- Set sel=511 via 511 pulses, one more pulse: cur_sel=0, blank entered, no X.
- ctrl_sel_rst_n low coinciding with an inc edge at sel=7: sel=0, never 8. Further edges during rst are ignored. After release, one edge gives sel=1.
- spine_ow usr=0x5A5A5A, guards=1: pad_usr_out=0x5A5A5A. Assert rst_n low mid-blank: spine_iw sel/ena/usr/guards all 0 immediately.
- With TT_SPINE_CTRL_SEL_LOAD_EN: load 0x1C3 in IDLE → cur_sel=0x1C3, ready low for 4 cycles. Load equal to current → no ena drop. Load + inc same cycle → sel=load value.
